// File: rtl/rle_encoder.sv
// ============================================================================
//  Module      : rle_encoder
//  Description : Streaming JPEG run-length encoder with a one-entry output
//                register. It emits {run, level} symbols and one EOB per block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rle_encoder #(
    parameter int COEF_W  = 11,
    parameter int RUN_W   = 6,
    parameter int LEVEL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COEF_W-1:0]        in_coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RUN_W+LEVEL_W-1:0] out_sym,
    output logic                     out_eob,
    output logic                     blk_done
);

    localparam logic [0:0] S_DATA = 1'b0;
    localparam logic [0:0] S_EOB  = 1'b1;

    localparam logic [RUN_W-1:0]   LAST_IDX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0]   EOB_RUN  = {RUN_W{1'b1}};
    localparam logic [LEVEL_W-1:0] LVL_MAX  = {1'b0, {(LEVEL_W-1){1'b1}}};
    localparam logic [LEVEL_W-1:0] LVL_MIN  = {1'b1, {(LEVEL_W-1){1'b0}}};

    logic [0:0]         state;
    logic [RUN_W-1:0]   idx;
    logic [RUN_W-1:0]   zrun;
    logic               in_beat;
    logic               out_beat;
    logic               coef_nz;
    logic               emit;
    logic               fits;
    logic [LEVEL_W-1:0] level;
    logic [COEF_W-LEVEL_W:0] upper;

    assign in_ready = (state == S_DATA) && (!out_valid || out_ready);
    assign in_beat  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;
    assign coef_nz  = |in_coef;
    assign emit     = (idx == '0) || coef_nz;

    // The coefficient fits the level field when every bit above the level sign matches it.
    assign upper = in_coef[COEF_W-1:LEVEL_W-1];
    assign fits  = (&upper) || !(|upper);

    always_comb begin
        level = in_coef[LEVEL_W-1:0];
        if (!fits) begin
            level = in_coef[COEF_W-1] ? LVL_MIN : LVL_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_DATA;
            idx       <= '0;
            zrun      <= '0;
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_eob   <= 1'b0;
            blk_done  <= 1'b0;
        end else begin
            blk_done <= out_beat && out_eob;

            if (out_beat) begin
                out_valid <= 1'b0;
                out_eob   <= 1'b0;
            end

            case (state)
                S_DATA: begin
                    if (in_beat) begin
                        idx <= idx + 1'b1;
                        if (emit) begin
                            out_valid <= 1'b1;
                            out_eob   <= 1'b0;
                            out_sym   <= {((idx == '0) ? '0 : zrun), level};
                            zrun      <= '0;
                        end else begin
                            zrun <= zrun + 1'b1;
                        end
                        // The last coefficient always closes the block, zero or not.
                        if (idx == LAST_IDX) begin
                            state <= S_EOB;
                            zrun  <= '0;
                        end
                    end
                end
                S_EOB: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_eob   <= 1'b1;
                        out_sym   <= {EOB_RUN, {LEVEL_W{1'b0}}};
                        state     <= S_DATA;
                    end
                end
                default: state <= S_DATA;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rle_encoder.sv
// Scoreboard bench for rle_encoder: the driver pushes expected symbols from a
// reference model, and the monitor pops them when the output handshake completes.
`default_nettype none

module tb_rle_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_coef;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_sym;
    logic        out_eob;
    logic        blk_done;

    rle_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sym   (out_sym),
        .out_eob   (out_eob),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sym_cnt  = 0;
    int eob_cnt  = 0;
    int done_cnt = 0;
    int nbeats, first_cyc, last_cyc;
    int m_idx, m_zrun;
    logic prev_eob_beat = 1'b0;
    logic [14:0] sbq[$];
    logic signed [10:0] blk [64];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] tsat(input int c);
        if (c > 127) return 8'h7F;
        if (c < -128) return 8'h80;
        return c[7:0];
    endfunction

    task automatic model_accept(input int c);
        if (m_idx == 0) begin
            sbq.push_back({1'b0, 6'd0, tsat(c)});
            m_zrun = 0;
        end else if (c != 0) begin
            sbq.push_back({1'b0, 6'(m_zrun), tsat(c)});
            m_zrun = 0;
        end else begin
            m_zrun++;
        end
        if (m_idx == 63) begin
            sbq.push_back({1'b1, 6'h3F, 8'h00});
            m_zrun = 0;
        end
        m_idx = (m_idx + 1) % 64;
    endtask

    // Monitor: pops the expected symbol on every output handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (blk_done || prev_eob_beat) check("blk_done", {31'd0, blk_done}, {31'd0, prev_eob_beat});
            if (blk_done) done_cnt++;
            if (out_valid && out_ready) begin
                sym_cnt++;
                if (out_eob) eob_cnt++;
                if (sbq.size() == 0) begin
                    check("unexpected_sym", {17'd0, out_eob, out_sym}, 32'hFFFF_FFFF);
                end else begin
                    logic [14:0] e;
                    e = sbq.pop_front();
                    check("out_sym", {18'd0, out_sym}, {18'd0, e[13:0]});
                    check("out_eob", {31'd0, out_eob}, {31'd0, e[14]});
                end
            end
            prev_eob_beat = out_valid && out_ready && out_eob;
        end else begin
            prev_eob_beat = 1'b0;
        end
    end

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            bit took = 0;
            int t = 0;
            in_valid = 1'b1;
            in_coef  = blk[i];
            while (!took && t < 100) begin
                @(negedge clk);
                if (in_ready) begin
                    took = 1;
                    model_accept(int'(blk[i]));
                    if (nbeats == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    nbeats++;
                end
                @(posedge clk);
                #1;
                t++;
            end
            if (!took) check("in_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", sbq.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = '0;
    endtask

    initial begin
        int s0, e0;
        rst_n = 1'b0; in_valid = 1'b0; in_coef = '0; out_ready = 1'b1;
        m_idx = 0; m_zrun = 0; nbeats = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sym",   {18'd0, out_sym},   32'd0);
        check("rst_out_eob",   {31'd0, out_eob},   32'd0);
        check("rst_blk_done",  {31'd0, blk_done},  32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // All-zero block: DC symbol plus EOB only
        clear_blk();
        s0 = sym_cnt;
        send(64);
        drain();
        check("zero_blk_syms", sym_cnt - s0, 32'd2);

        clear_blk();
        blk[0] = 11'sd5; blk[1] = -11'sd1; blk[63] = 11'sd3;
        send(64);
        drain();

        clear_blk();
        blk[0] = 11'sd300; blk[2] = -11'sd300;
        send(64);
        drain();

        // Output stall in the middle of a busy block
        for (int i = 0; i < 64; i++) blk[i] = 11'(i * 40 - 1000);
        fork
            send(64);
            begin
                repeat (20) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    if (sbq.size() > 0) check("stall_sym", {18'd0, out_sym}, {18'd0, sbq[0][13:0]});
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset part way through a block
        for (int i = 0; i < 64; i++) blk[i] = 11'(i + 1);
        send(30);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_sym",   {18'd0, out_sym},   32'd0);
        check("mid_rst_eob",   {31'd0, out_eob},   32'd0);
        sbq.delete();
        m_idx = 0; m_zrun = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_blk();
        blk[0] = -11'sd7; blk[5] = 11'sd1000; blk[40] = -11'sd129;
        send(64);
        drain();

        // Three back-to-back blocks
        nbeats = 0;
        e0 = eob_cnt;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 64; i++) begin
                int v;
                v = int'($urandom_range(800)) - 400;
                blk[i] = ($urandom_range(3) == 0) ? 11'(v) : 11'sd0;
            end
            send(64);
        end
        drain();
        check("b2b_cycles", last_cyc - first_cyc, 32'd193);
        check("b2b_eobs", eob_cnt - e0, 32'd3);
        check("blk_done_total", done_cnt, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
